// File: rtl/blake_nonce_dispatcher_pkg.sv
// Shared definitions for the Blake-512 nonce dispatcher: header geometry,
// FSM state encoding and the per-word byte swap.
package blake_nonce_dispatcher_pkg;
    localparam int DEF_HDR_W  = 640;
    localparam int WORD_W     = 32;
    localparam int NONCE_WORD = 19;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic [WORD_W-1:0] bswap32(input logic [WORD_W-1:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction
endpackage

// File: rtl/blake_nonce_dispatcher_if.sv
// Host/config and shared job-bus signals of the nonce dispatcher.
interface blake_nonce_dispatcher_if #(
    parameter int NUM_CORES = 2,
    parameter int HDR_W     = 640,
    parameter int NONCE_W   = 32
);
    logic                 start;
    logic                 abort;
    logic [HDR_W-1:0]     hdr_in;
    logic [NONCE_W-1:0]   nonce_start;
    logic [NONCE_W-1:0]   nonce_end;
    logic [NUM_CORES-1:0] core_ready;
    logic [NUM_CORES-1:0] core_valid;
    logic [HDR_W-1:0]     core_din;
    logic                 busy;
    logic                 done;
    logic [NONCE_W-1:0]   nonce_cur;

    modport master (
        output start, abort, hdr_in, nonce_start, nonce_end, core_ready,
        input  core_valid, core_din, busy, done, nonce_cur
    );

    modport slave (
        input  start, abort, hdr_in, nonce_start, nonce_end, core_ready,
        output core_valid, core_din, busy, done, nonce_cur
    );
endinterface

// File: rtl/blake_nonce_dispatcher_rr_grant.sv
// Combinational round-robin arbiter: first requester at or after ptr, cyclically.
module blake_nonce_dispatcher_rr_grant #(
    parameter int NUM_CORES = 2,
    parameter int PTR_W     = $clog2(NUM_CORES)
) (
    input  logic [NUM_CORES-1:0] req,
    input  logic [PTR_W-1:0]     ptr,
    output logic [NUM_CORES-1:0] grant,
    output logic                 any_grant
);
    int idx;

    always_comb begin
        grant     = '0;
        any_grant = 1'b0;
        idx       = 0;
        for (int i = 0; i < NUM_CORES; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_CORES) idx = idx - NUM_CORES;
            if (!any_grant && req[idx]) begin
                grant[idx] = 1'b1;
                any_grant  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/blake_nonce_dispatcher.sv
// Latches and byte-swaps a block header, then sweeps an inclusive nonce range,
// handing one {nonce, header} job per cycle to the hash cores in round-robin order.
module blake_nonce_dispatcher
    import blake_nonce_dispatcher_pkg::*;
#(
    parameter int NUM_CORES = 2,
    parameter int HDR_W     = DEF_HDR_W,
    parameter int NONCE_W   = WORD_W
) (
    input  logic                   clk,
    input  logic                   rst,
    blake_nonce_dispatcher_if.slave bus
);
    localparam int PTR_W  = $clog2(NUM_CORES);
    localparam int BODY_W = HDR_W - NONCE_W;

    state_t               state;
    logic [BODY_W-1:0]    hdr_sw;
    logic [BODY_W-1:0]    hdr_swapped;
    logic [NONCE_W-1:0]   nonce_cnt;
    logic [NONCE_W-1:0]   nonce_last;
    logic [PTR_W-1:0]     rr_ptr;
    logic [PTR_W-1:0]     grant_idx;
    logic [PTR_W-1:0]     next_ptr;
    logic [NUM_CORES-1:0] grant;
    logic                 any_grant;
    logic                 issue_ok;
    logic                 xfer;
    logic                 busy_q;
    logic                 done_q;

    // The incoming nonce word is overwritten by the counter, so it is never read.
    wire unused_nonce_word = &{1'b0, bus.hdr_in[HDR_W-1 -: NONCE_W]};

    always_comb begin
        hdr_swapped = '0;
        for (int k = 0; k < NONCE_WORD; k++)
            hdr_swapped[k*WORD_W +: WORD_W] = bswap32(bus.hdr_in[k*WORD_W +: WORD_W]);
    end

    blake_nonce_dispatcher_rr_grant #(
        .NUM_CORES (NUM_CORES),
        .PTR_W     (PTR_W)
    ) u_rr (
        .req       (bus.core_ready),
        .ptr       (rr_ptr),
        .grant     (grant),
        .any_grant (any_grant)
    );

    always_comb begin
        grant_idx = '0;
        for (int g = 0; g < NUM_CORES; g++)
            if (grant[g]) grant_idx = PTR_W'(g);
    end

    assign next_ptr = (grant_idx == PTR_W'(NUM_CORES - 1)) ? '0 : grant_idx + 1'b1;

    // Abort suppresses the strobe in the same cycle, so it beats any transfer.
    assign issue_ok       = (state == ST_ISSUE) && !bus.abort;
    assign xfer           = issue_ok && any_grant;
    assign bus.core_valid = issue_ok ? grant : '0;
    assign bus.core_din   = {nonce_cnt, hdr_sw};
    assign bus.nonce_cur  = nonce_cnt;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hdr_sw     <= '0;
            nonce_cnt  <= '0;
            nonce_last <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        state      <= ST_LOAD;
                        hdr_sw     <= hdr_swapped;
                        nonce_cnt  <= bus.nonce_start;
                        nonce_last <= bus.nonce_end;
                        busy_q     <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (bus.abort) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (bus.abort) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end else if (xfer) begin
                        rr_ptr <= next_ptr;
                        // Equality test covers the full 2^NONCE_W sweep without a wrap flag.
                        if (nonce_cnt == nonce_last) begin
                            state  <= ST_DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            nonce_cnt <= nonce_cnt + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
